// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: sequential PC generation, credit-limited request
// issue to an in-order variable-latency memory, and an instruction/PC FIFO toward decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_imem_req_vld,
  output logic [XLEN-1:0]          o_imem_req_addr,
  input  logic                     i_imem_req_rdy,
  input  logic                     i_imem_rsp_vld,
  input  logic [31:0]              i_imem_rsp_data,
  output logic                     o_insn_vld,
  output logic [31:0]              o_insn,
  output logic [XLEN-1:0]          o_pc,
  input  logic                     i_insn_rdy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [XLEN-1:0]          o_fetch_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]     insn_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire, rsp_fire, push, pop;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^i_redirect_pc[1:0];
  assign redirect_tgt   = {i_redirect_pc[XLEN-1:2], 2'b00};

  // Buffered plus in-flight entries may never exceed the FIFO size.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign o_imem_req_vld = i_reset && !i_redirect && (credit_used < (CW+1)'(DEPTH));
  assign o_insn_vld     = i_reset && !i_redirect && (count_q != '0);

  assign req_fire = o_imem_req_vld && i_imem_req_rdy;
  assign rsp_fire = i_imem_rsp_vld && (outst_q != '0);
  assign push     = rsp_fire && (drop_q == '0) && !i_redirect;
  assign pop      = o_insn_vld && i_insn_rdy;

  assign o_imem_req_addr = fetch_pc_q;
  assign o_fetch_pc      = fetch_pc_q;
  assign o_count         = count_q;
  assign o_insn          = insn_mem[rd_ptr_q];
  assign o_pc            = pc_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (i_redirect) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - CW'(rsp_fire);
      // Everything still in flight belongs to the abandoned path.
      drop_d     = outst_q - CW'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (push) begin
      insn_mem[wr_ptr_q] <= i_imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
